// File: rtl/frac_n_sdm_ctrl_pkg.sv
// Shared constants and types for the fractional-N modulus controller.
// This file also holds the MASH 1-1-1 carry cancellation helper.
package frac_n_pkg;

  localparam int FRAC_W_DEFAULT    = 16;
  localparam int INT_W_DEFAULT     = 6;
  localparam int MIN_RATIO_DEFAULT = 4;
  localparam int MAX_RATIO_DEFAULT = 63;

  typedef logic signed [3:0] sdm_offset_t;

  // Combines first-, second- and third-order carries into the divide offset (-3..+4).
  function automatic sdm_offset_t mash_offset(input logic c1, input logic c2, input logic c2_d,
                                              input logic c3, input logic c3_d, input logic c3_dd);
    sdm_offset_t y;
    y = $signed({3'b000, c1}) + $signed({3'b000, c2}) - $signed({3'b000, c2_d})
      + $signed({3'b000, c3}) - $signed({2'b00, c3_d, 1'b0}) + $signed({3'b000, c3_dd});
    return y;
  endfunction

endpackage

// File: rtl/frac_n_sdm_ctrl_if.sv
// Configuration handshake and divider-side signals of the modulus controller.
interface frac_n_sdm_ctrl_if
  import frac_n_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT,
  parameter int INT_W  = INT_W_DEFAULT
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              sdm_en;
  logic              div_load;
  logic [INT_W:0]    div_ratio;
  logic              sat_flag;

  modport master (
    output cfg_valid, cfg_int, cfg_frac, sdm_en, div_load,
    input  cfg_ready, div_ratio, sat_flag
  );

  modport slave (
    input  cfg_valid, cfg_int, cfg_frac, sdm_en, div_load,
    output cfg_ready, div_ratio, sat_flag
  );
endinterface

// File: rtl/frac_n_sdm_ctrl_acc_stage.sv
// One modulo-2^W accumulator of the MASH chain; sum/carry are the would-be next state.
module sdm_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);
  logic [W-1:0] acc_q;

  assign {carry_o, sum_o} = {1'b0, acc_q} + {1'b0, add_i};

  // Accumulator register: advances or clears only when the divider completes a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= clr_i ? '0 : sum_o;
    end
  end
endmodule

// File: rtl/frac_n_sdm_ctrl.sv
// Fractional-N modulus controller: shadowed config, MASH 1-1-1 modulator, clamped ratio.
// The modulator advances once per div_load pulse from the multi-modulus divider.
module frac_n_sdm_ctrl
  import frac_n_pkg::*;
#(
  parameter int FRAC_W    = FRAC_W_DEFAULT,
  parameter int INT_W     = INT_W_DEFAULT,
  parameter int MIN_RATIO = MIN_RATIO_DEFAULT,
  parameter int MAX_RATIO = MAX_RATIO_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  frac_n_sdm_ctrl_if.slave  bus
);
  localparam logic signed [INT_W+1:0] MIN_R = (INT_W+2)'(MIN_RATIO);
  localparam logic signed [INT_W+1:0] MAX_R = (INT_W+2)'(MAX_RATIO);

  logic [INT_W-1:0]  n_int_q, sh_int_q, n_int_d;
  logic [FRAC_W-1:0] n_frac_q, sh_frac_q, n_frac_d;
  logic              sh_full_q;
  logic              c2_d_q, c3_d_q, c3_dd_q;
  logic [INT_W:0]    div_ratio_q, div_ratio_d;
  logic              sat_flag_q, sat_d;

  logic              cfg_fire_s, clr_s;
  logic [FRAC_W-1:0] sum1_s, sum2_s, sum3_s;
  logic              c1_s, c2_s, c3_s;
  sdm_offset_t       y_s;
  logic signed [INT_W+1:0] r_s;

  assign bus.cfg_ready = ~sh_full_q;
  assign bus.div_ratio = div_ratio_q;
  assign bus.sat_flag  = sat_flag_q;
  assign cfg_fire_s    = bus.cfg_valid & ~sh_full_q;
  assign clr_s         = ~bus.sdm_en;

  sdm_acc_stage #(.W(FRAC_W)) u_acc1 (
    .clk(clk), .rst(rst), .en_i(bus.div_load), .clr_i(clr_s),
    .add_i(n_frac_d), .sum_o(sum1_s), .carry_o(c1_s)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_acc2 (
    .clk(clk), .rst(rst), .en_i(bus.div_load), .clr_i(clr_s),
    .add_i(sum1_s), .sum_o(sum2_s), .carry_o(c2_s)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_acc3 (
    .clk(clk), .rst(rst), .en_i(bus.div_load), .clr_i(clr_s),
    .add_i(sum2_s), .sum_o(sum3_s), .carry_o(c3_s)
  );

  // Word used for this step, modulator offset and clamped next ratio.
  always_comb begin
    n_int_d  = n_int_q;
    n_frac_d = n_frac_q;
    if (sh_full_q) begin
      n_int_d  = sh_int_q;
      n_frac_d = sh_frac_q;
    end else begin
      n_int_d  = n_int_q;
      n_frac_d = n_frac_q;
    end

    if (bus.sdm_en) begin
      y_s = mash_offset(c1_s, c2_s, c2_d_q, c3_s, c3_d_q, c3_dd_q);
    end else begin
      y_s = '0;
    end

    r_s         = $signed({2'b00, n_int_d}) + $signed({{(INT_W-2){y_s[3]}}, y_s});
    div_ratio_d = r_s[INT_W:0];
    sat_d       = 1'b0;
    if (r_s < MIN_R) begin
      div_ratio_d = MIN_R[INT_W:0];
      sat_d       = 1'b1;
    end else if (r_s > MAX_R) begin
      div_ratio_d = MAX_R[INT_W:0];
      sat_d       = 1'b1;
    end else begin
      div_ratio_d = r_s[INT_W:0];
      sat_d       = 1'b0;
    end
  end

  // Shadow handshake, active config, carry history and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_int_q     <= INT_W'(MIN_RATIO);
      n_frac_q    <= '0;
      sh_int_q    <= '0;
      sh_frac_q   <= '0;
      sh_full_q   <= 1'b0;
      c2_d_q      <= 1'b0;
      c3_d_q      <= 1'b0;
      c3_dd_q     <= 1'b0;
      div_ratio_q <= (INT_W+1)'(MIN_RATIO);
      sat_flag_q  <= 1'b0;
    end else begin
      // Acceptance needs an empty shadow and consumption needs a full one, so they never collide.
      if (cfg_fire_s) begin
        sh_int_q  <= bus.cfg_int;
        sh_frac_q <= bus.cfg_frac;
        sh_full_q <= 1'b1;
      end else if (bus.div_load) begin
        sh_full_q <= 1'b0;
      end

      if (bus.div_load) begin
        n_int_q     <= n_int_d;
        n_frac_q    <= n_frac_d;
        div_ratio_q <= div_ratio_d;
        if (sat_d) begin
          sat_flag_q <= 1'b1;
        end
        if (bus.sdm_en) begin
          c2_d_q  <= c2_s;
          c3_d_q  <= c3_s;
          c3_dd_q <= c3_d_q;
        end else begin
          c2_d_q  <= 1'b0;
          c3_d_q  <= 1'b0;
          c3_dd_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_frac_n_sdm_ctrl.sv
// Self-checking bench for frac_n_sdm_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic model of the MASH 1-1-1 controller.
module tb_frac_n_sdm_ctrl;
  localparam int FW = 16;
  localparam int IW = 6;
  localparam int MOD = 1 << FW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  frac_n_sdm_ctrl_if #(.FRAC_W(FW), .INT_W(IW)) bus ();

  frac_n_sdm_ctrl #(.FRAC_W(FW), .INT_W(IW), .MIN_RATIO(4), .MAX_RATIO(63)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Reference model state: plain integers, offsets from carry differences.
  int m_nint, m_nfrac, m_shint, m_shfrac;
  bit m_shfull;
  int m_acc[3];
  int m_c2_prev, m_c3_prev, m_c3_prev2;
  int m_ratio;
  bit m_sat;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_nint = 4; m_nfrac = 0; m_shint = 0; m_shfrac = 0; m_shfull = 1'b0;
    for (int k = 0; k < 3; k++) m_acc[k] = 0;
    m_c2_prev = 0; m_c3_prev = 0; m_c3_prev2 = 0;
    m_ratio = 4; m_sat = 1'b0;
  endtask

  task automatic model_step(input bit load, input bit valid, input int ci, input int cf, input bit en);
    bit accept;
    int c[3];
    int carry_in, y, r;
    accept = valid && !m_shfull;
    if (load) begin
      if (m_shfull) begin
        m_nint = m_shint; m_nfrac = m_shfrac; m_shfull = 1'b0;
      end
      y = 0;
      if (en) begin
        carry_in = m_nfrac;
        for (int k = 0; k < 3; k++) begin
          m_acc[k] = m_acc[k] + carry_in;
          c[k]     = m_acc[k] / MOD;
          m_acc[k] = m_acc[k] % MOD;
          carry_in = m_acc[k];
        end
        // first-order carry + first difference of c2 + second difference of c3
        y = c[0] + (c[1] - m_c2_prev) + (c[2] - 2 * m_c3_prev + m_c3_prev2);
        m_c3_prev2 = m_c3_prev; m_c3_prev = c[2]; m_c2_prev = c[1];
      end else begin
        for (int k = 0; k < 3; k++) m_acc[k] = 0;
        m_c2_prev = 0; m_c3_prev = 0; m_c3_prev2 = 0;
      end
      r = m_nint + y;
      if (r < 4) begin r = 4; m_sat = 1'b1; end
      else if (r > 63) begin r = 63; m_sat = 1'b1; end
      m_ratio = r;
    end
    if (accept) begin
      m_shint = ci; m_shfrac = cf; m_shfull = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.cfg_valid = 1'b0; bus.div_load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    check_eq("rst_ratio", bus.div_ratio, 4);
    check_eq("rst_ready", bus.cfg_ready, 1);
    check_eq("rst_sat", bus.sat_flag, 0);
  endtask

  task automatic step(input bit load, input bit valid, input int ci, input int cf, input bit en);
    @(negedge clk);
    bus.div_load  = load;
    bus.cfg_valid = valid;
    bus.cfg_int   = IW'(ci);
    bus.cfg_frac  = FW'(cf);
    bus.sdm_en    = en;
    @(posedge clk);
    model_step(load, valid, ci, cf, en);
    #1;
    bus.div_load  = 1'b0;
    bus.cfg_valid = 1'b0;
    check_eq("ready", bus.cfg_ready, m_shfull ? 0 : 1);
    check_eq("ratio", bus.div_ratio, m_ratio);
    check_eq("sat", bus.sat_flag, m_sat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[4];
    int sum, bad, r;
    seq[0] = 20; seq[1] = 22; seq[2] = 19; seq[3] = 21;
    bus.cfg_valid = 1'b0; bus.div_load = 1'b0; bus.sdm_en = 1'b1;
    bus.cfg_int = '0; bus.cfg_frac = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Integer-only word: ratio constant at N.
    step(0, 1, 20, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 1);
      check_eq("int_only", bus.div_ratio, 20);
    end

    // Half fraction from zero state: 20,22,19,21 pattern, offsets sum to 32.
    do_reset();
    step(0, 1, 20, 'h8000, 1);
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 0, 0, 1);
      if (i < 8) check_eq("half_seq", bus.div_ratio, seq[i % 4]);
      sum += int'(bus.div_ratio) - 20;
    end
    check_eq("half_sum", sum, 32);

    // Disabled modulator: config still applies, ratio = N, restart from zero.
    step(0, 1, 33, 'h8000, 0);
    step(1, 0, 0, 0, 0);
    check_eq("dis_ratio", bus.div_ratio, 33);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1);
      check_eq("reen_seq", bus.div_ratio, seq[i] + 13);
    end

    // Quarter fraction: average offset 1/4 and bounded excursion.
    do_reset();
    step(0, 1, 20, 'h4000, 1);
    sum = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 0, 1);
      r = int'(bus.div_ratio);
      sum += r - 20;
      if (r < 17 || r > 24) bad++;
    end
    check_eq("qtr_sum_ok", (sum >= 61 && sum <= 67) ? 1 : 0, 1);
    check_eq("qtr_range", bad, 0);

    // Lower clamp at MIN_RATIO; sat_flag sticky.
    do_reset();
    step(0, 1, 4, 'h8000, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check_eq("sat_before", bus.sat_flag, 0);
    step(1, 0, 0, 0, 1);
    check_eq("clamp_min", bus.div_ratio, 4);
    check_eq("sat_rise", bus.sat_flag, 1);
    step(0, 1, 20, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check_eq("sat_sticky", bus.sat_flag, 1);

    // Back-to-back offers with no load: second word is held off, then accepted.
    do_reset();
    step(0, 1, 25, 0, 1);
    check_eq("b2b_busy", bus.cfg_ready, 0);
    step(0, 1, 30, 0, 1);
    check_eq("b2b_held", bus.cfg_ready, 0);
    step(1, 1, 30, 0, 1);
    check_eq("b2b_first", bus.div_ratio, 25);
    check_eq("b2b_free", bus.cfg_ready, 1);
    step(0, 1, 30, 0, 1);
    check_eq("b2b_accept", bus.cfg_ready, 0);
    step(1, 0, 0, 0, 1);
    check_eq("b2b_second", bus.div_ratio, 30);

    // Reset with a pending shadow word discards it.
    step(0, 1, 40, 0, 1);
    do_reset();
    step(1, 0, 0, 0, 1);
    check_eq("rst_discard", bus.div_ratio, 4);

    // Randomized traffic against the model, including extreme words and resets.
    for (int i = 0; i < 1500; i++) begin
      int ci, cf, sel;
      if ($urandom_range(0, 299) == 0) do_reset();
      sel = $urandom_range(0, 9);
      ci  = (sel == 0) ? 0 : (sel == 1) ? 63 : $urandom_range(0, 63);
      sel = $urandom_range(0, 9);
      cf  = (sel == 0) ? 0 : (sel == 1) ? 'hFFFF : $urandom_range(0, 'hFFFF);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, ci, cf,
           $urandom_range(0, 7) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
